// File: rtl/text_overlay_pkg.sv
// Shared types and constants for the character-cell text overlay.
package text_overlay_pkg;

    localparam int unsigned CELL_W = 8;
    localparam int unsigned CELL_H = 16;
    localparam logic [6:0] ASCII_SPACE = 7'h20;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StClear
    } state_e;

    typedef struct packed {
        logic [6:0]  code;
        logic [11:0] fg;
    } cell_t;

endpackage

// File: rtl/text_overlay_if.sv
// Write/clear port used by the ride counters to place characters in the buffer.
interface text_overlay_if;

    logic        wr_valid;
    logic        wr_ready;
    logic        wr_page;
    logic [5:0]  wr_col;
    logic [3:0]  wr_row;
    logic [6:0]  wr_char;
    logic [11:0] wr_fg;
    logic        clr_req;

    modport master (
        output wr_valid, wr_page, wr_col, wr_row, wr_char, wr_fg, clr_req,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_page, wr_col, wr_row, wr_char, wr_fg, clr_req,
        output wr_ready
    );

endinterface

// File: rtl/ascii_rom.sv
// Compact 8x16 font: 'S' drawn explicitly, other printable codes show a code-derived bar pattern.
module ascii_rom (
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    logic [6:0] code;
    logic [3:0] row;

    assign code = addr[10:4];
    assign row  = addr[3:0];

    always_comb begin
        data = 8'h00;
        if (code == 7'h53) begin
            case (row)
                4'd2, 4'd11:              data = 8'h7C;
                4'd3, 4'd4, 4'd9, 4'd10:  data = 8'hC6;
                4'd5:                     data = 8'h60;
                4'd6:                     data = 8'h38;
                4'd7:                     data = 8'h0C;
                4'd8:                     data = 8'h06;
                default:                  data = 8'h00;
            endcase
        end else if (code > 7'h20 && code < 7'h7F && row >= 4'd2 && row <= 4'd13) begin
            data = {1'b0, code} ^ {4'h0, row};
        end
    end

endmodule

// File: rtl/text_buffer_ram.sv
// Simple dual-port cell buffer: one write port, one registered read port.
module text_buffer_ram #(
    parameter int unsigned Depth = 128,
    parameter int unsigned Width = 19,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_overlay.sv
// Two-page character-cell text engine: 3-stage pixel pipeline plus buffer init/clear FSM.
module text_overlay
    import text_overlay_pkg::*;
#(
    parameter int unsigned COLS     = 16,
    parameter int unsigned ROWS     = 4,
    parameter int unsigned ORIGIN_X = 80,
    parameter int unsigned ORIGIN_Y = 80,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [9:0]     x,
    input  logic [9:0]     y,
    input  logic           video_on,
    input  logic           hsync_in,
    input  logic           vsync_in,
    text_overlay_if.slave  wr,
    input  logic           page_req,
    input  logic [11:0]    bg_rgb,
    output logic [11:0]    rgb,
    output logic           hsync,
    output logic           vsync,
    output logic           video_out,
    output logic           text_hit,
    output logic           page_active
);

    localparam int unsigned Cells = COLS * ROWS;
    localparam int unsigned CellW = (Cells > 1) ? $clog2(Cells) : 1;
    localparam int unsigned AddrW = CellW + 1;

    // Control FSM and buffer write port
    state_e           state;
    logic [CellW-1:0] cnt;
    logic             cnt_page;
    logic             wr_ready_q;
    logic             last_cell;
    logic             host_in_range;
    logic [CellW-1:0] host_cell;
    logic             ram_we;
    logic [AddrW-1:0] ram_waddr;
    cell_t            ram_wdata;

    assign wr.wr_ready     = wr_ready_q;
    assign last_cell       = (cnt == CellW'(Cells - 1));
    assign host_in_range   = (32'(wr.wr_col) < COLS) && (32'(wr.wr_row) < ROWS);
    assign host_cell       = CellW'(32'(wr.wr_row) * COLS + 32'(wr.wr_col));

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = {cnt_page, cnt};
        ram_wdata = '{code: ASCII_SPACE, fg: 12'h000};
        case (state)
            StInit, StClear: ram_we = 1'b1;
            StIdle: begin
                ram_we    = wr.wr_valid && wr_ready_q && host_in_range;
                ram_waddr = {wr.wr_page, host_cell};
                ram_wdata = '{code: wr.wr_char, fg: wr.wr_fg};
            end
            default: ram_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StInit;
            cnt        <= '0;
            cnt_page   <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            case (state)
                StInit: begin
                    if (last_cell) begin
                        cnt <= '0;
                        if (cnt_page) begin
                            cnt_page   <= 1'b0;
                            state      <= StIdle;
                            wr_ready_q <= 1'b1;
                        end else begin
                            cnt_page <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CellW'(1);
                    end
                end
                StIdle: begin
                    // A write presented alongside clr_req has already landed this cycle.
                    if (wr.clr_req) begin
                        state      <= StClear;
                        cnt        <= '0;
                        cnt_page   <= wr.wr_page;
                        wr_ready_q <= 1'b0;
                    end
                end
                StClear: begin
                    if (last_cell) begin
                        state      <= StIdle;
                        cnt        <= '0;
                        wr_ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CellW'(1);
                    end
                end
                default: state <= StInit;
            endcase
        end
    end

    // Page swap only at the top of vertical blanking
    logic at_vact;
    logic at_vact_q;

    assign at_vact = (32'(y) == V_ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            at_vact_q   <= 1'b0;
            page_active <= 1'b0;
        end else begin
            at_vact_q <= at_vact;
            if (at_vact && !at_vact_q) begin
                page_active <= page_req;
            end
        end
    end

    // Pixel pipeline
    logic [31:0]      px, py, col_c, row_c;
    logic             in_win_c;
    logic [CellW-1:0] cell_c;
    logic             s1_win, s2_win;
    logic [AddrW-1:0] s1_addr;
    logic [2:0]       s1_gx, s2_gx;
    logic [3:0]       s1_gy, s2_gy;
    logic [2:0]       hs_q, vs_q, vo_q;
    cell_t            rd_cell;
    logic [7:0]       rom_data;
    logic             lit;

    assign px       = 32'(x);
    assign py       = 32'(y);
    assign in_win_c = (px >= ORIGIN_X) && (px < ORIGIN_X + CELL_W * COLS) &&
                      (py >= ORIGIN_Y) && (py < ORIGIN_Y + CELL_H * ROWS);
    assign col_c    = (px - ORIGIN_X) >> 3;
    assign row_c    = (py - ORIGIN_Y) >> 4;
    assign cell_c   = CellW'(row_c * COLS + col_c);

    text_buffer_ram #(
        .Depth (2 ** AddrW),
        .Width ($bits(cell_t)),
        .AddrW (AddrW)
    ) u_buf (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (s1_addr),
        .rdata (rd_cell)
    );

    ascii_rom u_rom (
        .addr (({rd_cell.code, s2_gy})),
        .data (rom_data)
    );

    assign lit = s2_win && rom_data[3'd7 - s2_gx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_win   <= 1'b0;
            s1_addr  <= '0;
            s1_gx    <= '0;
            s1_gy    <= '0;
            s2_win   <= 1'b0;
            s2_gx    <= '0;
            s2_gy    <= '0;
            hs_q     <= '1;
            vs_q     <= '1;
            vo_q     <= '0;
            rgb      <= 12'h000;
            text_hit <= 1'b0;
        end else begin
            s1_win   <= in_win_c;
            s1_addr  <= {page_active, cell_c};
            s1_gx    <= x[2:0];
            s1_gy    <= y[3:0];
            s2_win   <= s1_win;
            s2_gx    <= s1_gx;
            s2_gy    <= s1_gy;
            hs_q     <= {hs_q[1:0], hsync_in};
            vs_q     <= {vs_q[1:0], vsync_in};
            vo_q     <= {vo_q[1:0], video_on};
            rgb      <= !vo_q[1] ? 12'h000 : (lit ? rd_cell.fg : bg_rgb);
            text_hit <= lit && vo_q[1];
        end
    end

    assign hsync     = hs_q[2];
    assign vsync     = vs_q[2];
    assign video_out = vo_q[2];

endmodule

// File: tb/tb_text_overlay.sv
// Self-checking bench for text_overlay: directed table, reference-model scans and random traffic.
module tb_text_overlay;

    localparam int COLS = 16;
    localparam int ROWS = 4;
    localparam int OX   = 80;
    localparam int OY   = 80;
    localparam int VA   = 480;
    localparam logic [127:0] S_ROWS = 128'h0000_7CC6_C660_380C_06C6_C67C_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x = '0, y = '0;
    logic        video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, page_req = 1'b0;
    logic [11:0] bg_rgb = '0;
    logic [11:0] rgb;
    logic        hsync, vsync, video_out, text_hit, page_active;

    text_overlay_if wr ();

    text_overlay #(
        .COLS (COLS), .ROWS (ROWS), .ORIGIN_X (OX), .ORIGIN_Y (OY), .V_ACTIVE (VA)
    ) dut (
        .clk (clk), .rst_n (rst_n), .x (x), .y (y), .video_on (video_on),
        .hsync_in (hsync_in), .vsync_in (vsync_in), .wr (wr), .page_req (page_req),
        .bg_rgb (bg_rgb), .rgb (rgb), .hsync (hsync), .vsync (vsync),
        .video_out (video_out), .text_hit (text_hit), .page_active (page_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model of the buffer contents and displayed page
    logic [6:0]  m_code [2][ROWS][COLS];
    logic [11:0] m_fg   [2][ROWS][COLS];
    int          m_page = 0;

    typedef struct {
        logic [15:0] v;
        int          px;
        int          py;
    } exp_t;
    exp_t eq[$];

    typedef struct {
        int          px;
        int          py;
        bit          vo;
        logic [11:0] rgb;
        bit          hit;
    } vec_t;
    vec_t tv[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] glyph(input logic [6:0] code, input int r);
        logic [127:0] s_rows;
        s_rows = S_ROWS;
        if (code == 7'h53) return s_rows[127 - 8 * r -: 8];
        if (code > 7'h20 && code < 7'h7F && r >= 2 && r <= 13) return {1'b0, code} ^ 8'(r);
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    m_code[p][r][c] = 7'h20;
                    m_fg[p][r][c]   = 12'h000;
                end
    endtask

    task automatic model_pix(input int px, input int py, input bit vo,
                             output logic [11:0] e_rgb, output bit e_hit);
        int c, r;
        logic [7:0] g;
        bit b;
        e_rgb = 12'h000;
        e_hit = 1'b0;
        b = 1'b0;
        c = 0;
        r = 0;
        if (vo) begin
            if (px >= OX && px < OX + 8 * COLS && py >= OY && py < OY + 16 * ROWS) begin
                c = (px - OX) / 8;
                r = (py - OY) / 16;
                g = glyph(m_code[m_page][r][c], py % 16);
                b = g[7 - (px % 8)];
            end
            e_rgb = b ? m_fg[m_page][r][c] : bg_rgb;
            e_hit = b;
        end
    endtask

    // Drive one pixel; outputs seen now belong to the pixel driven three steps earlier.
    task automatic step(input int px, input int py, input bit vo, input bit hs, input bit vs,
                        input logic [11:0] e_rgb, input bit e_hit);
        exp_t e;
        x = 10'(px); y = 10'(py); video_on = vo; hsync_in = hs; vsync_in = vs;
        e.v = {e_rgb, e_hit, hs, vs, vo};
        e.px = px;
        e.py = py;
        eq.push_back(e);
        tick();
        if (eq.size() == 3) begin
            e = eq.pop_front();
            chk($sformatf("pixel(%0d,%0d) {rgb,hit,hs,vs,vo}", e.px, e.py),
                {rgb, text_hit, hsync, vsync, video_out}, e.v);
        end
    endtask

    task automatic mstep(input int px, input int py, input bit vo, input bit hs, input bit vs);
        logic [11:0] e_rgb;
        bit e_hit;
        model_pix(px, py, vo, e_rgb, e_hit);
        step(px, py, vo, hs, vs, e_rgb, e_hit);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) mstep(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        eq.delete();
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++)
                mstep(xx, yy, 1'b1, (xx % 7) == 0, (yy % 5) == 0);
        flush();
    endtask

    task automatic rand_pix(input int n);
        int px, py;
        eq.delete();
        bg_rgb = 12'($urandom);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                px = $urandom_range(0, 639);
                py = $urandom_range(0, 479);
            end else begin
                px = $urandom_range(70, 220);
                py = $urandom_range(70, 150);
            end
            mstep(px, py, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
        end
        flush();
    endtask

    task automatic do_write(input bit pg, input int col, input int row, input logic [6:0] ch,
                            input logic [11:0] fg, input bit clr);
        bit ok;
        ok = 1'b0;
        wr.wr_valid = 1'b1; wr.wr_page = pg; wr.wr_col = 6'(col); wr.wr_row = 4'(row);
        wr.wr_char = ch; wr.wr_fg = fg; wr.clr_req = clr;
        for (int i = 0; i < 300; i++) begin
            if (wr.wr_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        wr.wr_valid = 1'b0;
        wr.clr_req = 1'b0;
        chk("write handshake", 32'(ok), 32'd1);
        if (ok && col < COLS && row < ROWS) begin
            m_code[pg][row][col] = ch;
            m_fg[pg][row][col]   = fg;
        end
    endtask

    task automatic wait_ready(input string name, input int exp_n);
        int n;
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (wr.wr_ready) begin
                n = i;
                break;
            end
        end
        chk(name, 32'(n), 32'(exp_n));
    endtask

    task automatic swap_to(input bit p);
        page_req = p;
        mstep(0, VA - 1, 1'b0, 1'b1, 1'b0);
        mstep(0, VA, 1'b0, 1'b1, 1'b0);
        chk("page_active after swap", 32'(page_active), 32'(p));
        mstep(0, VA + 1, 1'b0, 1'b1, 1'b0);
        m_page = int'(p);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        wr.wr_valid = 1'b0; wr.wr_page = 1'b0; wr.wr_col = '0; wr.wr_row = '0;
        wr.wr_char = '0; wr.wr_fg = '0; wr.clr_req = 1'b0;
        model_reset();

        // Reset state with live-looking inputs
        x = 10'd81; y = 10'd82; video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("reset rgb", 32'(rgb), 32'h0);
        chk("reset text_hit", 32'(text_hit), 32'h0);
        chk("reset hsync", 32'(hsync), 32'h1);
        chk("reset vsync", 32'(vsync), 32'h1);
        chk("reset video_out", 32'(video_out), 32'h0);
        chk("reset page_active", 32'(page_active), 32'h0);
        chk("reset wr_ready", 32'(wr.wr_ready), 32'h0);

        // INIT length with a held out-of-range write
        wr.wr_valid = 1'b1; wr.wr_col = 6'd20; wr.wr_row = 4'd0; wr.wr_char = 7'h41;
        wr.wr_fg = 12'hF00;
        rst_n = 1'b1;
        chk("wr_ready right after release", 32'(wr.wr_ready), 32'h0);
        wait_ready("init busy cycles", 2 * COLS * ROWS);
        tick();
        wr.wr_valid = 1'b0;
        bg_rgb = 12'h008;
        scan(OX - 2, OX + 8 * COLS + 1, OY - 2, OY + 16 * ROWS + 1);

        // 'S' at page 0 cell (0,0): hand-derived table
        do_write(1'b0, 0, 0, 7'h53, 12'hFFF, 1'b0);
        tv[0]  = '{80, 80, 1'b1, 12'h008, 1'b0};
        tv[1]  = '{80, 82, 1'b1, 12'h008, 1'b0};
        tv[2]  = '{81, 82, 1'b1, 12'hFFF, 1'b1};
        tv[3]  = '{85, 82, 1'b1, 12'hFFF, 1'b1};
        tv[4]  = '{86, 82, 1'b1, 12'h008, 1'b0};
        tv[5]  = '{80, 85, 1'b1, 12'h008, 1'b0};
        tv[6]  = '{81, 85, 1'b1, 12'hFFF, 1'b1};
        tv[7]  = '{87, 88, 1'b1, 12'h008, 1'b0};
        tv[8]  = '{86, 88, 1'b1, 12'hFFF, 1'b1};
        tv[9]  = '{81, 82, 1'b0, 12'h000, 1'b0};
        tv[10] = '{79, 83, 1'b1, 12'h008, 1'b0};
        tv[11] = '{88, 83, 1'b1, 12'h008, 1'b0};
        tv[12] = '{81, 96, 1'b1, 12'h008, 1'b0};
        tv[13] = '{208, 100, 1'b1, 12'h008, 1'b0};
        tv[14] = '{81, 144, 1'b1, 12'h008, 1'b0};
        tv[15] = '{207, 143, 1'b1, 12'h008, 1'b0};
        tv[16] = '{80, 89, 1'b1, 12'hFFF, 1'b1};
        eq.delete();
        for (int i = 0; i < 17; i++)
            step(tv[i].px, tv[i].py, tv[i].vo, 1'(i), 1'(i + 1), tv[i].rgb, tv[i].hit);
        flush();
        scan(OX, OX + 7, OY, OY + 15);

        // Random writes across both pages, including out-of-range coordinates
        do_write(1'b1, 3, 2, 7'h53, 12'h0F0, 1'b0);
        for (int i = 0; i < 40; i++)
            do_write(1'($urandom), $urandom_range(0, COLS + 3), $urandom_range(0, ROWS + 1),
                     7'($urandom_range(32, 126)), 12'($urandom), 1'b0);
        rand_pix(500);

        // Mid-frame page request takes effect only at the first y == V_ACTIVE
        eq.delete();
        page_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mstep(100 + i, 200, 1'b1, 1'b0, 1'b1);
            chk("page_active mid-frame", 32'(page_active), 32'h0);
        end
        mstep(0, VA - 1, 1'b0, 1'b1, 1'b0);
        chk("page_active before V_ACTIVE", 32'(page_active), 32'h0);
        mstep(0, VA, 1'b0, 1'b1, 1'b0);
        chk("page_active at V_ACTIVE", 32'(page_active), 32'h1);
        page_req = 1'b0;
        mstep(1, VA, 1'b0, 1'b1, 1'b0);
        chk("page_active holds on repeated V_ACTIVE line", 32'(page_active), 32'h1);
        m_page = 1;
        flush();
        rand_pix(500);

        // Clear with a same-cycle write; a clr_req during CLEAR must be ignored
        do_write(1'b1, 2, 1, 7'h41, 12'h123, 1'b1);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            wr.clr_req = (i == 5);
            wr.wr_page = 1'b0;
            tick();
            if (wr.wr_ready) begin
                n = i;
                break;
            end
        end
        wr.clr_req = 1'b0;
        chk("clear busy cycles", 32'(n), COLS * ROWS);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                m_code[1][r][c] = 7'h20;
                m_fg[1][r][c]   = 12'h000;
            end
        bg_rgb = 12'h0A5;
        scan(OX - 1, OX + 8 * COLS, OY - 1, OY + 16 * ROWS);
        eq.delete();
        swap_to(1'b0);
        rand_pix(400);

        // Out-of-range writes complete but change nothing
        do_write(1'b0, 20, 0, 7'h58, 12'hABC, 1'b0);
        do_write(1'b0, 3, 7, 7'h59, 12'hCBA, 1'b0);
        scan(OX, OX + 8 * COLS - 1, OY, OY + 16 * ROWS - 1);

        // Reset asserted mid-CLEAR, then a full INIT
        do_write(1'b0, 0, 0, 7'h53, 12'hFFF, 1'b0);
        do_write(1'b1, 0, 0, 7'h20, 12'h000, 1'b1);
        x = 10'd81; y = 10'd82; video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("lit pixel before reset", 32'(rgb), 32'hFFF);
        chk("hsync before reset", 32'(hsync), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid-clear reset rgb", 32'(rgb), 32'h0);
        chk("mid-clear reset hsync", 32'(hsync), 32'h1);
        chk("mid-clear reset vsync", 32'(vsync), 32'h1);
        chk("mid-clear reset text_hit", 32'(text_hit), 32'h0);
        chk("mid-clear reset wr_ready", 32'(wr.wr_ready), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_ready("re-init busy cycles", 2 * COLS * ROWS);
        model_reset();
        m_page = 0;
        bg_rgb = 12'h321;
        scan(OX, OX + 8 * COLS - 1, OY, OY + 16 * ROWS - 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
